qqspi_arbiter: RTL and testbench

Two-port round-robin arbiter directly upstream of the `qqspi` controller. It accepts word requests from the instruction-fetch port (m0) and the data port (m1), and decodes the chip index from the upper address bits. It drives one `qqspi` transaction at a time, including its `ce_ctrl`, `PSRAM_SPIFLASH` and `QUAD_MODE` inputs, and returns `rdata`/`ready` to the granted port.

---
 rtl/qqspi_arb_pkg.sv | 19 +
 rtl/qqspi_rr_arb2.sv | 29 ++
 rtl/qqspi_arbiter.sv | 162 ++++++++++++++++
 tb/tb_qqspi_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qqspi_arb_pkg.sv
// qqspi_arbiter shared types: FSM states, address split and port ids.
// Optional read buffer is enabled by defining QQSPI_ARB_RDBUF_EN.
package qqspi_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACK,
    S_DRAIN
  } arb_state_t;

  localparam int ADDR_W     = 25;
  localparam int CHIP_IDX_W = 2;
  localparam int WADDR_W    = ADDR_W - CHIP_IDX_W;

  localparam logic PORT_M0 = 1'b0;
  localparam logic PORT_M1 = 1'b1;

endpackage

// File: rtl/qqspi_rr_arb2.sv
// Two-request round-robin picker; owns the last_grant register.
// Grant is combinational; last_grant follows grant[1] when take is high.
module qqspi_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] grant,
  output logic       last_grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= 1'b1;
    else if (take)
      last_grant <= grant[1];
  end

endmodule

// File: rtl/qqspi_arbiter.sv
// Two-port round-robin front end for one qqspi controller.
// Define QQSPI_ARB_RDBUF_EN for a one-entry tagged read buffer.
module qqspi_arbiter
  import qqspi_arb_pkg::*;
#(
  parameter int                      CHIP_SELECTS = 3,
  parameter logic [CHIP_SELECTS-1:0] PSRAM_MASK   = 3'b001,
  parameter logic [CHIP_SELECTS-1:0] QUAD_MASK    = 3'b000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_valid,
  input  logic [ADDR_W-1:0]       m0_addr,
  input  logic [31:0]             m0_wdata,
  input  logic [3:0]              m0_wstrb,
  output logic                    m0_ready,
  output logic [31:0]             m0_rdata,
  input  logic                    m1_valid,
  input  logic [ADDR_W-1:0]       m1_addr,
  input  logic [31:0]             m1_wdata,
  input  logic [3:0]              m1_wstrb,
  output logic                    m1_ready,
  output logic [31:0]             m1_rdata,
  output logic                    mem_valid,
  output logic [WADDR_W-1:0]      mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [3:0]              mem_wstrb,
  output logic [CHIP_SELECTS-1:0] mem_ce_ctrl,
  output logic                    mem_psram_spiflash,
  output logic                    mem_quad_mode,
  input  logic                    mem_ready,
  input  logic [31:0]             mem_rdata
);

  arb_state_t state, state_nx;

  logic [1:0]            req, grant;
  logic                  take, last_grant;
  logic                  port, direct;
  logic [ADDR_W-1:0]     w_addr;
  logic [31:0]           w_wdata;
  logic [3:0]            w_wstrb;
  logic [CHIP_IDX_W-1:0] w_idx;
  logic                  w_in_range, hit;

  assign req  = {m1_valid, m0_valid};
  assign take = (state == S_IDLE) && (|req);

  qqspi_rr_arb2 u_rr (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .take       (take),
    .grant      (grant),
    .last_grant (last_grant)
  );

  assign w_addr  = grant[1] ? m1_addr  : m0_addr;
  assign w_wdata = grant[1] ? m1_wdata : m0_wdata;
  assign w_wstrb = grant[1] ? m1_wstrb : m0_wstrb;
  assign w_idx   = w_addr[ADDR_W-1 -: CHIP_IDX_W];

  assign w_in_range =
    {30'd0, w_idx} < 32'(CHIP_SELECTS);

`ifdef QQSPI_ARB_RDBUF_EN
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_tag, cur_tag;
  logic [31:0]       buf_data;

  assign hit = buf_valid && (buf_tag == w_addr)
             && (w_wstrb == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      cur_tag   <= '0;
      buf_data  <= '0;
    end else if (take && w_in_range && !hit) begin
      cur_tag <= w_addr;
      if (w_wstrb != 4'd0 && buf_tag == w_addr)
        buf_valid <= 1'b0;
    end else if (state == S_REQ && mem_ready
                 && mem_wstrb == 4'd0) begin
      buf_valid <= 1'b1;
      buf_tag   <= cur_tag;
      buf_data  <= mem_rdata;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (|req)
          state_nx = (w_in_range && !hit) ? S_REQ : S_ACK;
      S_REQ:
        if (mem_ready) state_nx = S_ACK;
      S_ACK:
        state_nx = direct ? S_IDLE : S_DRAIN;
      S_DRAIN:
        if (!mem_ready) state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Hit and out-of-range grants bypass qqspi and ack straight from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port               <= PORT_M0;
      direct             <= 1'b0;
      mem_valid          <= 1'b0;
      mem_addr           <= '0;
      mem_wdata          <= '0;
      mem_wstrb          <= '0;
      mem_ce_ctrl        <= '0;
      mem_psram_spiflash <= 1'b0;
      mem_quad_mode      <= 1'b0;
      m0_rdata           <= '0;
      m1_rdata           <= '0;
    end else if (take) begin
      port <= grant[1];
      if (w_in_range && !hit) begin
        direct             <= 1'b0;
        mem_valid          <= 1'b1;
        mem_addr           <= w_addr[WADDR_W-1:0];
        mem_wdata          <= w_wdata;
        mem_wstrb          <= w_wstrb;
        mem_ce_ctrl        <= CHIP_SELECTS'(1) << w_idx;
        mem_psram_spiflash <= PSRAM_MASK[w_idx];
        mem_quad_mode      <= QUAD_MASK[w_idx];
      end else begin
        direct <= 1'b1;
`ifdef QQSPI_ARB_RDBUF_EN
        if (grant[1]) m1_rdata <= hit ? buf_data : '0;
        else          m0_rdata <= hit ? buf_data : '0;
`else
        if (grant[1]) m1_rdata <= '0;
        else          m0_rdata <= '0;
`endif
      end
    end else if (state == S_REQ && mem_ready) begin
      mem_valid <= 1'b0;
      if (port == PORT_M1) m1_rdata <= mem_rdata;
      else                 m0_rdata <= mem_rdata;
    end
  end

  assign m0_ready = (state == S_ACK) && (port == PORT_M0);
  assign m1_ready = (state == S_ACK) && (port == PORT_M1);

endmodule

// File: tb/tb_qqspi_arbiter.sv
// Scoreboard bench for qqspi_arbiter with a qqspi-like responder.
// Buffer cases run only when QQSPI_ARB_RDBUF_EN is defined.
module tb_qqspi_arbiter;
  import qqspi_arb_pkg::*;

  logic        clk, rst;
  logic        m0_valid, m1_valid, m0_ready, m1_ready;
  logic [24:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        mem_valid, mem_ready, mem_psram_spiflash, mem_quad_mode;
  logic [22:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [2:0]  mem_ce_ctrl;

  typedef struct packed {
    logic [22:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  ce;
    logic        ps;
    logic        qd;
  } mtx_t;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } rsp_t;

  rsp_t        sb_q[$];
  mtx_t        mem_q[$];
  logic [31:0] resp_q[$];

  int errors = 0;
  int checks = 0;
  int mv_rises = 0;
  int lat0, lat1, r0;

  qqspi_arbiter #(
    .CHIP_SELECTS (3),
    .PSRAM_MASK   (3'b001),
    .QUAD_MASK    (3'b000)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .m0_valid           (m0_valid),
    .m0_addr            (m0_addr),
    .m0_wdata           (m0_wdata),
    .m0_wstrb           (m0_wstrb),
    .m0_ready           (m0_ready),
    .m0_rdata           (m0_rdata),
    .m1_valid           (m1_valid),
    .m1_addr            (m1_addr),
    .m1_wdata           (m1_wdata),
    .m1_wstrb           (m1_wstrb),
    .m1_ready           (m1_ready),
    .m1_rdata           (m1_rdata),
    .mem_valid          (mem_valid),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_wstrb          (mem_wstrb),
    .mem_ce_ctrl        (mem_ce_ctrl),
    .mem_psram_spiflash (mem_psram_spiflash),
    .mem_quad_mode      (mem_quad_mode),
    .mem_ready          (mem_ready),
    .mem_rdata          (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got nothing expected an entry", name);
  endtask

  // Responder: ready three cycles after valid, cleared only after valid drops.
  initial begin : responder
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else if (mem_valid && !mem_ready) begin
        cnt++;
        if (cnt == 3) begin
          mem_ready = 1'b1;
          mem_rdata = (resp_q.size() > 0) ? resp_q.pop_front() : 32'd0;
          cnt = 0;
        end
      end else if (!mem_valid && mem_ready) begin
        mem_ready = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic prev_mv;
    rsp_t e;
    mtx_t m;
    prev_mv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_valid && !prev_mv) begin
          mv_rises++;
          chk("stale_ready", {63'd0, mem_ready}, 64'd0);
          if (mem_q.size() == 0) miss("mem_unexpected");
          else begin
            m = mem_q.pop_front();
            chk("mem_txn", {mem_addr, mem_wdata, mem_wstrb, mem_ce_ctrl,
                            mem_psram_spiflash, mem_quad_mode}, m);
          end
        end
        if (m0_ready || m1_ready) begin
          chk("one_ready", {63'd0, m0_ready & m1_ready}, 64'd0);
          if (sb_q.size() == 0) miss("ready_unexpected");
          else begin
            e = sb_q.pop_front();
            chk("grant_port", {63'd0, m1_ready}, {63'd0, e.port});
            chk("port_rdata", {32'd0, m1_ready ? m1_rdata : m0_rdata},
                {32'd0, e.data});
          end
        end
      end
      prev_mv = rst ? 1'b0 : mem_valid;
    end
  end

  task automatic exp_mem(input logic p, input logic [24:0] a,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input logic [2:0] ce, input logic ps,
                         input logic qd, input logic [31:0] rsp);
    mem_q.push_back({a[22:0], wd, ws, ce, ps, qd});
    resp_q.push_back(rsp);
    sb_q.push_back({p, rsp});
  endtask

  task automatic req(input logic p, input logic [24:0] a,
                     input logic [31:0] wd, input logic [3:0] ws,
                     output int lat);
    logic done;
    if (!p) begin
      m0_valid = 1'b1; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
    end else begin
      m1_valid = 1'b1; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
    end
    lat = 0;
    done = 1'b0;
    while (!done && lat < 300) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      done = p ? m1_ready : m0_ready;
    end
    if (!done) miss("req_timeout");
    @(posedge clk);
    #1;
    if (!p) m0_valid = 1'b0;
    else    m1_valid = 1'b0;
  endtask

  task automatic idle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int n;
    rst = 1'b1;
    m0_valid = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;

    @(negedge clk);
    chk("rst_valid_ce", {60'd0, mem_valid, mem_ce_ctrl}, 64'd0);
    chk("rst_readies", {62'd0, m0_ready, m1_ready}, 64'd0);
    chk("rst_addr_strb", {37'd0, mem_addr, mem_wstrb}, 64'd0);
    chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
    chk("rst_ps_qd", {62'd0, mem_psram_spiflash, mem_quad_mode}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // both from reset: m0 first, then alternate
    exp_mem(0, {2'd0, 23'h100}, 0, 0, 3'b001, 1, 0, 32'h11111111);
    exp_mem(1, {2'd0, 23'h200}, 0, 0, 3'b001, 1, 0, 32'h22222222);
    fork
      req(0, {2'd0, 23'h100}, 0, 0, lat0);
      req(1, {2'd0, 23'h200}, 0, 0, lat1);
    join
    exp_mem(0, {2'd0, 23'h300}, 0, 0, 3'b001, 1, 0, 32'h33333333);
    exp_mem(1, {2'd0, 23'h400}, 0, 0, 3'b001, 1, 0, 32'h44444444);
    fork
      req(0, {2'd0, 23'h300}, 0, 0, lat0);
      req(1, {2'd0, 23'h400}, 0, 0, lat1);
    join

    // lone m0 read
    idle();
    exp_mem(0, {2'd0, 23'h10}, 0, 0, 3'b001, 1, 0, 32'hDEADBEEF);
    req(0, {2'd0, 23'h10}, 0, 0, lat0);

    // m1 write to chip 1 wins over pending m0 read
    idle();
    exp_mem(1, {2'd1, 23'h40}, 32'h12345678, 4'b0011, 3'b010, 0, 0, 32'h0);
    exp_mem(0, {2'd0, 23'h20}, 0, 0, 3'b001, 1, 0, 32'h0F0F0F0F);
    fork
      req(1, {2'd1, 23'h40}, 32'h12345678, 4'b0011, lat1);
      req(0, {2'd0, 23'h20}, 0, 0, lat0);
    join

    // chip index 3: immediate ack, rdata 0, no qqspi access
    idle();
    r0 = mv_rises;
    sb_q.push_back({1'b0, 32'h0});
    req(0, {2'd3, 23'h7}, 0, 0, lat0);
    chk("oor_rd_latency", 64'(lat0), 64'd1);
    sb_q.push_back({1'b1, 32'h0});
    req(1, {2'd3, 23'h8}, 32'hFFFFFFFF, 4'hF, lat1);
    chk("oor_wr_latency", 64'(lat1), 64'd1);
    idle();
    chk("oor_no_mem", 64'(mv_rises), 64'(r0));

`ifdef QQSPI_ARB_RDBUF_EN
    idle();
    exp_mem(1, {2'd0, 23'h55}, 0, 0, 3'b001, 1, 0, 32'hCAFEF00D);
    req(1, {2'd0, 23'h55}, 0, 0, lat1);
    idle();
    r0 = mv_rises;
    sb_q.push_back({1'b1, 32'hCAFEF00D});
    req(1, {2'd0, 23'h55}, 0, 0, lat1);
    chk("hit_latency", 64'(lat1), 64'd1);
    idle();
    chk("hit_no_mem", 64'(mv_rises), 64'(r0));
    exp_mem(0, {2'd0, 23'h55}, 32'h1, 4'hF, 3'b001, 1, 0, 32'h0);
    req(0, {2'd0, 23'h55}, 32'h1, 4'hF, lat0);
    idle();
    r0 = mv_rises;
    exp_mem(1, {2'd0, 23'h55}, 0, 0, 3'b001, 1, 0, 32'h0BADF00D);
    req(1, {2'd0, 23'h55}, 0, 0, lat1);
    chk("inval_mem_access", 64'(mv_rises), 64'(r0 + 1));
`endif

    // reset while REQ
    idle();
    mem_q.push_back({23'h99, 32'h0, 4'h0, 3'b100, 1'b0, 1'b0});
    m0_valid = 1'b1; m0_addr = {2'd2, 23'h99}; m0_wdata = 0; m0_wstrb = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_valid && n < 20);
    if (!mem_valid) miss("rst_req_timeout");
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid_ce", {60'd0, mem_valid, mem_ce_ctrl}, 64'd0);
    chk("midrst_readies", {62'd0, m0_ready, m1_ready}, 64'd0);
    m0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    exp_mem(0, {2'd2, 23'h99}, 0, 0, 3'b100, 0, 0, 32'h5A5A5A5A);
    req(0, {2'd2, 23'h99}, 0, 0, lat0);

    idle();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    chk("mem_q_empty", 64'(mem_q.size()), 64'd0);
    chk("resp_q_empty", 64'(resp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
